// File: rtl/itof_pipe_if.sv
// rtl/itof_pipe_if.sv - request/result handshake bundle for the int32 -> float converter
interface itof_pipe_if #(
  parameter int TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      s;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      d;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, s, in_tag, out_ready,
    input  in_ready, out_valid, d, out_tag
  );

  modport slave (
    input  in_valid, s, in_tag, out_ready,
    output in_ready, out_valid, d, out_tag
  );
endinterface

// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - pipelined int32 -> IEEE-754 single converter (fcvt.s.w), RNE rounding
// Operand capture rank, then sign/abs, normalise and round ranks; one global stall for all ranks.
module itof_pipe #(
  parameter int TAG_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  itof_pipe_if.slave io
);

  logic             stall;
  logic             adv;

  logic             v0_q;
  logic [31:0]      s0_q;
  logic [TAG_W-1:0] tag0_q;

  logic             v1_q;
  logic             sgn1_q;
  logic             zero1_q;
  logic [31:0]      mag1_q;
  logic [TAG_W-1:0] tag1_q;
  logic             sgn1_d;
  logic             zero1_d;
  logic [31:0]      mag1_d;

  logic             v2_q;
  logic             sgn2_q;
  logic             zero2_q;
  logic [30:0]      m2_q;
  logic [7:0]       e2_q;
  logic [TAG_W-1:0] tag2_q;
  logic [4:0]       lz2;
  logic [30:0]      m2_d;
  logic [7:0]       e2_d;

  logic             v3_q;
  logic [31:0]      d3_q;
  logic [TAG_W-1:0] tag3_q;
  logic [22:0]      frac3;
  logic             guard3;
  logic             sticky3;
  logic             inc3;
  logic [30:0]      ef3;
  logic [31:0]      d3_d;

  assign stall        = v3_q && !io.out_ready;
  assign adv          = !stall;
  assign io.in_ready  = adv;
  assign io.out_valid = v3_q;
  assign io.d         = d3_q;
  assign io.out_tag   = tag3_q;

  // -2^31 negates to itself, which read as unsigned is exactly the wanted magnitude
  always_comb begin
    sgn1_d  = s0_q[31];
    mag1_d  = s0_q[31] ? (~s0_q + 32'd1) : s0_q;
    zero1_d = (s0_q == 32'd0);
  end

  always_comb begin
    lz2 = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag1_q[i]) begin
        lz2 = 5'(31 - i);
      end
    end
    m2_d = 31'(mag1_q << lz2);
    e2_d = 8'd158 - {3'b000, lz2};
  end

  // Rounding into the packed {e, frac} lets a fraction carry bump the exponent for free
  always_comb begin
    frac3   = m2_q[30:8];
    guard3  = m2_q[7];
    sticky3 = |m2_q[6:0];
    inc3    = guard3 && (sticky3 || frac3[0]);
    ef3     = {e2_q, frac3} + {30'd0, inc3};
    d3_d    = zero2_q ? 32'h0000_0000 : {sgn2_q, ef3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q    <= 1'b0;
      s0_q    <= 32'd0;
      tag0_q  <= '0;
      v1_q    <= 1'b0;
      sgn1_q  <= 1'b0;
      zero1_q <= 1'b0;
      mag1_q  <= 32'd0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      sgn2_q  <= 1'b0;
      zero2_q <= 1'b0;
      m2_q    <= 31'd0;
      e2_q    <= 8'd0;
      tag2_q  <= '0;
      v3_q    <= 1'b0;
      d3_q    <= 32'd0;
      tag3_q  <= '0;
    end else if (adv) begin
      v0_q    <= io.in_valid;
      s0_q    <= io.s;
      tag0_q  <= io.in_tag;
      v1_q    <= v0_q;
      sgn1_q  <= sgn1_d;
      zero1_q <= zero1_d;
      mag1_q  <= mag1_d;
      tag1_q  <= tag0_q;
      v2_q    <= v1_q;
      sgn2_q  <= sgn1_q;
      zero2_q <= zero1_q;
      m2_q    <= m2_d;
      e2_q    <= e2_d;
      tag2_q  <= tag1_q;
      v3_q    <= v2_q;
      d3_q    <= d3_d;
      tag3_q  <= tag2_q;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - self-checking bench for itof_pipe
module tb_itof_pipe;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  logic [36:0] exp_q[$];
  logic [36:0] act_q[$];
  int          in_edge_q[$];
  int          out_edge_q[$];

  itof_pipe_if #(.TAG_W(TAG_W)) io ();

  itof_pipe #(.TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: int -> double is exact, then round the double mantissa to 23 bits (RNE)
  function automatic logic [31:0] model(input logic [31:0] x);
    real         r;
    logic [63:0] b;
    logic [28:0] rem;
    logic [30:0] ef;
    logic        inc;
    if (x == 32'd0) return 32'd0;
    r   = $itor($signed(x));
    b   = $realtobits(r);
    ef  = {8'(b[62:52] - 11'd896), b[51:29]};
    rem = b[28:0];
    inc = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && b[29]);
    return {b[63], ef + {30'd0, inc}};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (io.in_valid && io.in_ready) begin
        exp_q.push_back({model(io.s), io.in_tag});
        in_edge_q.push_back(cyc + 1);
      end
      if (io.out_valid && io.out_ready) begin
        act_q.push_back({io.d, io.out_tag});
        out_edge_q.push_back(cyc);
      end
    end
  end

  task automatic clear_q();
    exp_q.delete();
    act_q.delete();
    in_edge_q.delete();
    out_edge_q.delete();
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int k = 0; k < budget && act_q.size() < n; k++) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] val, input logic [TAG_W-1:0] tag);
    @(posedge clk);
    #1;
    io.in_valid = v;
    io.s        = val;
    io.in_tag   = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.in_valid = 1'b0; io.s = 32'd0; io.in_tag = '0; io.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (io.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", io.out_valid); end
    checks++; if (io.d !== 32'd0) begin fails++; $display("FAIL reset_d got=%h want=00000000", io.d); end
    checks++; if (io.out_tag !== 5'd0) begin fails++; $display("FAIL reset_out_tag got=%0d want=0", io.out_tag); end
    checks++; if (io.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", io.in_ready); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] sv[8] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
                           32'h7FFF_FFFF, 32'd16777217, 32'd16777219, 32'hFEFF_FFFB};
    logic [31:0] dv[8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000,
                           32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'hCB80_0002};
    clear_q();
    io.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, sv[i], 5'(i));
    drive(1'b0, 32'd0, '0);
    wait_out(8, 30);
    checks++; if (act_q.size() != 8) begin fails++; $display("FAIL directed_count got=%0d want=8", act_q.size()); end
    for (int i = 0; i < 8 && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== {dv[i], 5'(i)}) begin
        fails++; $display("FAIL directed_%0d s=%h got d=%h tag=%0d want d=%h tag=%0d",
                          i, sv[i], act_q[i][36:5], act_q[i][4:0], dv[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    io.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 12345 - 60000), 5'(i));
      @(negedge clk);
      checks++; if (io.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready_%0d got=%b want=1", i, io.in_ready); end
    end
    drive(1'b0, 32'd0, '0);
    wait_out(10, 30);
    checks++; if (act_q.size() != 10) begin fails++; $display("FAIL b2b_count got=%0d want=10", act_q.size()); end
    if (act_q.size() == 10 && in_edge_q.size() == 10) begin
      checks++;
      if (out_edge_q[0] - in_edge_q[0] != 3) begin
        fails++; $display("FAIL b2b_latency got=%0d want=3", out_edge_q[0] - in_edge_q[0]);
      end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (act_q[i] !== {model(32'(i * 12345 - 60000)), 5'(i)}) begin
          fails++; $display("FAIL b2b_item_%0d got=%h want=%h", i, act_q[i], {model(32'(i * 12345 - 60000)), 5'(i)});
        end
        checks++;
        if (out_edge_q[i] != out_edge_q[0] + i) begin
          fails++; $display("FAIL b2b_gap_%0d got=%0d want=%0d", i, out_edge_q[i], out_edge_q[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_d;
    logic [4:0]  hold_t;
    clear_q();
    io.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 7777777 - 20000000), 5'(i));
    drive(1'b1, 32'(4 * 7777777 - 20000000), 5'd4);
    io.out_ready = 1'b0;
    @(negedge clk);
    hold_d = io.d;
    hold_t = io.out_tag;
    checks++;
    if (hold_d !== model(32'(-20000000)) || hold_t !== 5'd0) begin
      fails++; $display("FAIL bp_head got d=%h tag=%0d want d=%h tag=0", hold_d, hold_t, model(32'(-20000000)));
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (io.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_%0d got=%b want=0", k, io.in_ready); end
      checks++;
      if (io.d !== hold_d || io.out_tag !== hold_t || io.out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_stable_%0d got d=%h tag=%0d v=%b want d=%h tag=%0d v=1",
                          k, io.d, io.out_tag, io.out_valid, hold_d, hold_t);
      end
      @(posedge clk);
    end
    #1; io.out_ready = 1'b1;
    drive(1'b0, 32'd0, '0);
    wait_out(5, 30);
    checks++; if (act_q.size() != 5) begin fails++; $display("FAIL bp_count got=%0d want=5", act_q.size()); end
    for (int i = 0; i < 5 && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== {model(32'(i * 7777777 - 20000000)), 5'(i)}) begin
        fails++; $display("FAIL bp_item_%0d got=%h want=%h", i, act_q[i], {model(32'(i * 7777777 - 20000000)), 5'(i)});
      end
    end
  endtask

  task automatic test_bubbles();
    logic [3:0] pat = 4'b0101;
    logic       want;
    clear_q();
    io.out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      drive((j < 4) ? pat[j] : 1'b0, 32'(j + 1), 5'(j));
      @(negedge clk);
      want = (j >= 4 && j < 8) ? pat[j - 4] : 1'b0;
      checks++;
      if (io.out_valid !== want) begin
        fails++; $display("FAIL bubble_slot_%0d got=%b want=%b", j, io.out_valid, want);
      end
    end
    checks++; if (act_q.size() != 2) begin fails++; $display("FAIL bubble_count got=%0d want=2", act_q.size()); end
  endtask

  task automatic test_reset_midflight();
    clear_q();
    io.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'(1000 + i), 5'(i + 20));
    drive(1'b0, 32'd0, '0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (io.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got=%b want=0", io.out_valid); end
    checks++; if (io.d !== 32'd0) begin fails++; $display("FAIL rstmid_d got=%h want=00000000", io.d); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (act_q.size() != 0) begin fails++; $display("FAIL rstmid_stale got=%0d want=0", act_q.size()); end
  endtask

  task automatic test_random();
    int          accepted = 0;
    logic        need_new = 1'b1;
    logic [31:0] v;
    clear_q();
    for (int c = 0; c < 30000 && accepted < 1000; c++) begin
      @(posedge clk); #1;
      if (need_new) begin
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 32'h0200_0000);
            2: v = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: v = $urandom >> $urandom_range(0, 31);
          endcase
          if ($urandom_range(0, 1) != 0) v = -v;
          io.in_valid = 1'b1; io.s = v; io.in_tag = 5'($urandom);
          need_new = 1'b0;
        end else begin
          io.in_valid = 1'b0;
        end
      end
      io.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (io.in_valid && io.in_ready) begin
        accepted++;
        need_new = 1'b1;
      end
    end
    drive(1'b0, 32'd0, '0);
    io.out_ready = 1'b1;
    wait_out(1000, 50);
    checks++; if (accepted != 1000) begin fails++; $display("FAIL rand_accepted got=%0d want=1000", accepted); end
    checks++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL rand_item_%0d got=%h want=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
